// File: rtl/ser_to_par_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ser_to_par_pkg
// Description : Shared types and constants for the serial-to-parallel
//               receiver: receive state enum, default word width and the
//               helper that sizes the bit-index counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ser_to_par_pkg;

  // Receive phase: collecting data bits, or waiting for the trailing parity
  // bit. PARITY is only reachable when SER_TO_PAR_RX_PARITY_EN is defined.
  typedef enum logic [0:0] {
    DATA   = 1'b0,
    PARITY = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold an index in 0..n-1 (never less than 1).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage : ser_to_par_pkg
`default_nettype wire

// File: rtl/ser_to_par_hold.sv
`default_nettype none
// ============================================================================
// Module      : ser_to_par_hold
// Description : Output holding register for the serial-to-parallel receiver.
//               Captures a completed word when the slot is empty or being
//               drained in the same cycle; otherwise drops it and raises a
//               sticky overrun flag.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               load_valid      - a word completes this cycle
//               load_data       - the completed word
//               load_perr       - parity error flag travelling with the word
//               out_ready       - consumer accepts when out_valid is high
//               out_data        - held word
//               out_valid       - out_data holds an unconsumed word
//               overrun         - sticky: a completed word was dropped
//               parity_err      - parity error of the word in out_data
// Revision    : 1.0 - initial release
// ============================================================================
module ser_to_par_hold
  import ser_to_par_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_perr,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             overrun,
  output logic             parity_err
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             perr_q, perr_d;

  logic             w_accept;
  logic             w_can_load;

  assign w_accept   = valid_q & out_ready;
  // The slot is free if it is empty, or if its word leaves this same cycle.
  assign w_can_load = ~valid_q | out_ready;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    perr_d    = perr_q;

    if (w_accept) begin
      valid_d = 1'b0;
    end

    if (load_valid) begin
      if (w_can_load) begin
        data_d  = load_data;
        valid_d = 1'b1;
        perr_d  = load_perr;
      end else begin
        // Held word is kept intact; the new one (and its parity) is lost.
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      perr_q    <= perr_d;
    end
  end

  assign out_data   = data_q;
  assign out_valid  = valid_q;
  assign overrun    = overrun_q;
  assign parity_err = perr_q;

endmodule : ser_to_par_hold
`default_nettype wire

// File: rtl/ser_to_par_rx.sv
`default_nettype none
// ============================================================================
// Module      : ser_to_par_rx
// Description : Serial-to-parallel receiver. Assembles WIDTH bits LSB-first
//               from a strobed serial stream, realigns on sync, and presents
//               each completed word through a valid/ready holding register.
//               Optional even parity bit per word: define
//               SER_TO_PAR_RX_PARITY_EN to enable it.
// Ports       : clk         - rising-edge clock
//               reset       - synchronous active-high reset
//               din         - serial data bit
//               en          - bit strobe, din consumed this cycle
//               sync        - current bit is bit 0, drop any partial word
//               out_data    - assembled word
//               out_valid   - out_data holds an unconsumed word
//               out_ready   - consumer accept
//               overrun     - sticky: a completed word was dropped
//               parity_err  - parity mismatch of the word in out_data
// Revision    : 1.0 - initial release
// ============================================================================
module ser_to_par_rx
  import ser_to_par_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

  localparam int               IDX_W    = clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;

  logic             word_done;
  logic [WIDTH-1:0] word_data;
  logic             word_perr;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    word_data = shreg_q;
    word_perr = 1'b0;

    if (sync) begin
      // Realign regardless of where we are; a strobed bit here is bit 0.
      state_d = DATA;
      idx_d   = '0;
      shreg_d = '0;
      if (en) begin
        shreg_d[0] = din;
        idx_d      = IDX_W'(1);
      end
    end else if (en) begin
      case (state_q)
        DATA: begin
          shreg_d[idx_q] = din;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef SER_TO_PAR_RX_PARITY_EN
            state_d = PARITY;
`else
            word_done = 1'b1;
            word_data = shreg_d;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        PARITY: begin
`ifdef SER_TO_PAR_RX_PARITY_EN
          // Even parity: data bits plus parity bit must XOR to zero.
          word_done = 1'b1;
          word_data = shreg_q;
          word_perr = (^shreg_q) ^ din;
`endif
          state_d = DATA;
        end
        default: state_d = DATA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DATA;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  ser_to_par_hold #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load_valid (word_done),
    .load_data  (word_data),
    .load_perr  (word_perr),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

endmodule : ser_to_par_rx
`default_nettype wire

// File: tb/tb_ser_to_par_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ser_to_par_rx
// Description : Directed self-checking bench for ser_to_par_rx (WIDTH=8).
//               Parity scenarios are included when SER_TO_PAR_RX_PARITY_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ser_to_par_rx;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             din;
  logic             en;
  logic             sync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             parity_err;

  int n_checks;
  int n_fail;

  ser_to_par_rx #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .en         (en),
    .sync       (sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic rdy);
    din       = b;
    en        = 1'b1;
    out_ready = rdy;
    tick();
    din       = 1'b0;
    en        = 1'b0;
    out_ready = 1'b0;
  endtask

  // Full word, LSB first, plus correct even parity when enabled. rdy_last
  // raises out_ready on the word's final strobe.
  task automatic send_word(input logic [7:0] d, input logic rdy_last);
    for (int i = 0; i < 8; i++) begin
`ifdef SER_TO_PAR_RX_PARITY_EN
      send_bit(d[i], 1'b0);
`else
      send_bit(d[i], (i == 7) ? rdy_last : 1'b0);
`endif
    end
`ifdef SER_TO_PAR_RX_PARITY_EN
    send_bit(^d, rdy_last);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] v;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    din       = 1'b0;
    en        = 1'b0;
    sync      = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_ovr", 32'(overrun), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);

    // Word 0xA5 after sync, with idle strobe-free cycles mid-word
    pulse_sync();
    v = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      send_bit(v[i], 1'b0);
      if (i == 3) begin
        tick();
        tick();
      end
    end
    check("a5_pre_valid", 32'(out_valid), 32'h0);
    send_bit(v[7], 1'b0);
`ifdef SER_TO_PAR_RX_PARITY_EN
    check("a5_pre_par_valid", 32'(out_valid), 32'h0);
    send_bit(^v, 1'b0);
`endif
    check("a5_valid", 32'(out_valid), 32'h1);
    check("a5_data", 32'(out_data), 32'hA5);
    tick();
    check("a5_hold_data", 32'(out_data), 32'hA5);
    accept();
    check("a5_accept_valid", 32'(out_valid), 32'h0);

    // Second word arrives while the first is unread
    send_word(8'h3C, 1'b0);
    check("w1_data", 32'(out_data), 32'h3C);
    check("w1_ovr", 32'(overrun), 32'h0);
    send_word(8'h55, 1'b0);
    check("ovr_kept_data", 32'(out_data), 32'h3C);
    check("ovr_valid", 32'(out_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    accept();
    check("ovr_after_acc_valid", 32'(out_valid), 32'h0);
    check("ovr_after_acc", 32'(overrun), 32'h1);
    pulse_sync();
    check("ovr_after_sync", 32'(overrun), 32'h1);

    // Accept and load in the same cycle
    do_reset();
    check("rst2_ovr", 32'(overrun), 32'h0);
    send_word(8'h12, 1'b0);
    check("w12_data", 32'(out_data), 32'h12);
    send_word(8'h34, 1'b1);
    check("swap_valid", 32'(out_valid), 32'h1);
    check("swap_data", 32'(out_data), 32'h34);
    check("swap_ovr", 32'(overrun), 32'h0);
    accept();
    check("swap_acc_valid", 32'(out_valid), 32'h0);

    // Resync mid-word with a strobed bit
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    din  = 1'b1;
    en   = 1'b1;
    sync = 1'b1;
    tick();
    din  = 1'b0;
    en   = 1'b0;
    sync = 1'b0;
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
`ifdef SER_TO_PAR_RX_PARITY_EN
    send_bit(1'b1, 1'b0);
`endif
    check("resync_valid", 32'(out_valid), 32'h1);
    check("resync_data", 32'(out_data), 32'h01);

    // Sync without strobe: partial discarded, held word untouched
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    pulse_sync();
    check("sync_noen_valid", 32'(out_valid), 32'h1);
    check("sync_noen_data", 32'(out_data), 32'h01);
    accept();
    send_word(8'h80, 1'b0);
    check("sync_noen_next", 32'(out_data), 32'h80);

    // Reset mid-word
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    do_reset();
    check("midrst_valid", 32'(out_valid), 32'h0);
    check("midrst_data", 32'(out_data), 32'h00);
    check("midrst_ovr", 32'(overrun), 32'h0);
    check("midrst_perr", 32'(parity_err), 32'h0);
    send_word(8'hFF, 1'b0);
    check("midrst_ff_valid", 32'(out_valid), 32'h1);
    check("midrst_ff_data", 32'(out_data), 32'hFF);
    accept();

`ifdef SER_TO_PAR_RX_PARITY_EN
    // Even parity: 0x07 has three ones
    do_reset();
    v = 8'h07;
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
    check("par_ok_pre_valid", 32'(out_valid), 32'h0);
    send_bit(1'b1, 1'b0);
    check("par_ok_valid", 32'(out_valid), 32'h1);
    check("par_ok_data", 32'(out_data), 32'h07);
    check("par_ok_perr", 32'(parity_err), 32'h0);
    accept();
    for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
    check("par_bad_pre_valid", 32'(out_valid), 32'h0);
    send_bit(1'b0, 1'b0);
    check("par_bad_valid", 32'(out_valid), 32'h1);
    check("par_bad_perr", 32'(parity_err), 32'h1);
    // A dropped good-parity word must leave the error flag alone
    send_word(8'h07, 1'b0);
    check("par_drop_ovr", 32'(overrun), 32'h1);
    check("par_drop_perr", 32'(parity_err), 32'h1);
`else
    check("noparity_perr", 32'(parity_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_ser_to_par_rx
`default_nettype wire
